// File: rtl/lamp_pkg.sv
// lamp_pkg: shared constants and shifter state encoding for the LED lamp datapath
package lamp_pkg;
   localparam int c_board_channels = 32;
   localparam int c_def_bpc = 12;
   localparam int c_def_max_time = 480;
   typedef enum logic [2:0] {IDLE, FETCH, SHIFT, LATCH, HOLD} t_shift_state;
endpackage

// File: rtl/bit_serializer.sv
// bit_serializer: shifts one word MSB-first with c_clkdiv-cycle serial-clock phases
module bit_serializer
   import lamp_pkg::*;
#(
   parameter int c_bpc = c_def_bpc,
   parameter int c_clkdiv = 2
)(
   input  logic             i_clk,
   input  logic             i_rstn,
   input  logic             i_load,
   input  logic [c_bpc-1:0] i_data,
   output logic             o_sclk,
   output logic             o_sdata,
   output logic             o_done
);
   localparam int c_bit_w = $clog2(c_bpc);
   localparam int c_div_w = $clog2(c_clkdiv + 1);
   logic [c_bpc-2:0] sreg;
   logic [c_bit_w-1:0] bit_cnt;
   logic [c_div_w-1:0] div_cnt;
   logic active;
   assign o_done = active && o_sclk && div_cnt == '0 && bit_cnt == '0;
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         sreg <= '0;
         bit_cnt <= '0;
         div_cnt <= '0;
         active <= 1'b0;
         o_sclk <= 1'b0;
         o_sdata <= 1'b0;
      end else if (i_load) begin
         sreg <= i_data[c_bpc-2:0];
         o_sdata <= i_data[c_bpc-1];
         bit_cnt <= c_bit_w'(c_bpc - 1);
         div_cnt <= c_div_w'(c_clkdiv - 1);
         o_sclk <= 1'b0;
         active <= 1'b1;
      end else if (active) begin
         if (div_cnt != '0) begin
            div_cnt <= div_cnt - 1'b1;
         end else begin
            div_cnt <= c_div_w'(c_clkdiv - 1);
            o_sclk <= ~o_sclk;
            // next bit is presented on the same edge that drops the serial clock
            if (o_sclk) begin
               if (bit_cnt == '0) begin
                  active <= 1'b0;
                  o_sdata <= 1'b0;
               end else begin
                  bit_cnt <= bit_cnt - 1'b1;
                  o_sdata <= sreg[c_bpc-2];
                  sreg <= sreg << 1;
               end
            end
         end
      end
   end
endmodule

// File: rtl/framebuffer_shifter.sv
// framebuffer_shifter: scans the framebuffer top-down, serialises every channel, latches and holds
module framebuffer_shifter
   import lamp_pkg::*;
#(
   parameter int c_ledboards = 30,
   parameter int c_channels = c_ledboards * c_board_channels,
   parameter int c_addr_w = $clog2(c_channels),
   parameter int c_bpc = c_def_bpc,
   parameter int c_max_time = c_def_max_time,
   parameter int c_time_w = $clog2(c_max_time),
   parameter int c_clkdiv = 2,
   parameter int c_tick = 1000
)(
   input  logic                i_clk,
   input  logic                i_rstn,
   input  logic                i_en,
   output logic [c_addr_w-1:0] o_raddr,
   input  logic [c_bpc-1:0]    i_rdata,
   input  logic [c_time_w-1:0] i_time,
   output logic                o_sclk,
   output logic                o_sdata,
   output logic                o_latch,
   output logic                o_busy,
   output logic                o_frame_done
);
   localparam int c_hold_w = $clog2(c_max_time * c_tick);
   localparam int c_lat_w = $clog2(c_clkdiv + 1);
   localparam logic [c_addr_w-1:0] c_top_addr = c_addr_w'(c_channels - 1);
   t_shift_state state;
   logic f_ph;
   logic ser_done;
   logic lat_first;
   logic [c_lat_w-1:0] lat_cnt;
   logic [c_time_w-1:0] time_sat;
   logic [c_hold_w-1:0] hold_cnt, hold_val, hold_nxt;
   bit_serializer #(.c_bpc(c_bpc), .c_clkdiv(c_clkdiv)) u_ser (
      .i_clk  (i_clk),
      .i_rstn (i_rstn),
      .i_load (state == FETCH && f_ph),
      .i_data (i_rdata),
      .o_sclk (o_sclk),
      .o_sdata(o_sdata),
      .o_done (ser_done)
   );
   always_comb begin
      time_sat = ({1'b0, i_time} >= (c_time_w + 1)'(c_max_time)) ? c_time_w'(c_max_time - 1) : i_time;
      hold_val = c_hold_w'(time_sat) * c_hold_w'(c_tick);
      lat_first = lat_cnt == c_lat_w'(c_clkdiv - 1);
      hold_nxt = (state == LATCH && lat_first) ? hold_val : hold_cnt;
   end
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state <= IDLE;
         f_ph <= 1'b0;
         lat_cnt <= '0;
         hold_cnt <= '0;
         o_raddr <= c_top_addr;
         o_latch <= 1'b0;
         o_busy <= 1'b0;
         o_frame_done <= 1'b0;
      end else begin
         case (state)
            IDLE: if (i_en) begin
               state <= FETCH;
               o_busy <= 1'b1;
            end
            FETCH: begin
               f_ph <= ~f_ph;
               if (f_ph) state <= SHIFT;
            end
            SHIFT: if (ser_done) begin
               if (o_raddr != '0) begin
                  o_raddr <= o_raddr - 1'b1;
                  state <= FETCH;
               end else begin
                  state <= LATCH;
                  o_latch <= 1'b1;
                  lat_cnt <= c_lat_w'(c_clkdiv - 1);
               end
            end
            LATCH: begin
               hold_cnt <= hold_nxt;
               if (lat_cnt == '0) begin
                  o_latch <= 1'b0;
                  o_frame_done <= hold_nxt == '0;
                  state <= HOLD;
               end else begin
                  lat_cnt <= lat_cnt - 1'b1;
               end
            end
            HOLD: if (hold_cnt == '0) begin
               // the last HOLD cycle doubles as the frame_done slot
               o_frame_done <= 1'b0;
               o_raddr <= c_top_addr;
               o_busy <= i_en;
               state <= i_en ? FETCH : IDLE;
            end else begin
               hold_cnt <= hold_cnt - 1'b1;
               o_frame_done <= hold_cnt == c_hold_w'(1);
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_framebuffer_shifter.sv
// tb_framebuffer_shifter: directed checks of scan order, serial data, latch, hold, enable and reset
module tb_framebuffer_shifter;
   logic clk = 1'b0;
   logic rstn = 1'b0;
   logic en = 1'b0;
   logic [4:0] raddr;
   logic [11:0] rdata;
   logic [8:0] tval = '0;
   logic sclk, sdata, latch, busy, fdone;
   logic [11:0] mem [32];
   int checks = 0;
   int errors = 0;
   bit bits[$];
   int addrs[$];
   int lat_cnt, lat_fall, fd_cyc, busy_lo, first_addr, first_busy;
   logic prev_sclk, prev_lat;

   always #5 clk = ~clk;
   always @(posedge clk) rdata <= mem[raddr];

   framebuffer_shifter #(.c_ledboards(1), .c_clkdiv(1), .c_tick(4)) dut (
      .i_clk(clk), .i_rstn(rstn), .i_en(en), .o_raddr(raddr), .i_rdata(rdata),
      .i_time(tval), .o_sclk(sclk), .o_sdata(sdata), .o_latch(latch),
      .o_busy(busy), .o_frame_done(fdone)
   );

   task automatic fill(input logic [11:0] v);
      for (int i = 0; i < 32; i++) mem[i] = v;
   endtask

   task automatic run_frame(input int drop_at, input int wr_cyc, input int wr_addr,
                            input logic [11:0] wr_data, input int budget);
      bits.delete();
      addrs.delete();
      lat_cnt = 0; lat_fall = -1; fd_cyc = -1; busy_lo = 0;
      prev_sclk = 1'b0; prev_lat = 1'b0;
      for (int c = 1; c <= budget && fd_cyc < 0; c++) begin
         @(negedge clk);
         if (c == 1) begin first_addr = int'(raddr); first_busy = int'(busy); end
         if (addrs.size() == 0 || addrs[$] != int'(raddr)) addrs.push_back(int'(raddr));
         if (!prev_sclk && sclk) bits.push_back(sdata);
         if (latch) lat_cnt++;
         if (prev_lat && !latch && lat_fall < 0) lat_fall = c;
         if (!busy) busy_lo++;
         if (fdone) fd_cyc = c;
         prev_sclk = sclk;
         prev_lat = latch;
         if (c == drop_at) en = 1'b0;
         if (c == wr_cyc) mem[wr_addr] = wr_data;
      end
   endtask

   function automatic logic [11:0] word_at(input int j);
      logic [11:0] w = 'x;
      if (bits.size() >= 12 * (j + 1))
         for (int b = 0; b < 12; b++) w = {w[10:0], 1'(bits[12 * j + b])};
      return w;
   endfunction

   task automatic start_frame();
      @(negedge clk);
      en = 1'b1;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      checks++;
      if (raddr !== 5'd31) begin errors++; $display("FAIL reset_raddr: got %0d want 31", raddr); end
      checks++;
      if ({sclk, sdata, latch, busy, fdone} !== 5'b0) begin
         errors++; $display("FAIL reset_outputs: got %b want 00000", {sclk, sdata, latch, busy, fdone});
      end
      rstn = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b want 0", busy); end
   endtask

   task automatic test_single_word();
      int ones12 = 0, ones = 0;
      fill(12'h000);
      mem[31] = 12'hFFF;
      tval = 9'd0;
      start_frame();
      run_frame(1, -1, 0, 12'h0, 1000);
      for (int i = 0; i < bits.size(); i++) begin
         ones += int'(bits[i]);
         if (i < 12) ones12 += int'(bits[i]);
      end
      checks++;
      if (bits.size() != 384) begin errors++; $display("FAIL t1_bitcount: got %0d want 384", bits.size()); end
      checks++;
      if (ones12 != 12 || ones != 12) begin
         errors++; $display("FAIL t1_bits: ones_first12 %0d ones_total %0d want 12 12", ones12, ones);
      end
      checks++;
      if (lat_cnt != 1) begin errors++; $display("FAIL t1_latch_len: got %0d want 1", lat_cnt); end
      checks++;
      if (fd_cyc != 834) begin errors++; $display("FAIL t1_frame_done_cycle: got %0d want 834", fd_cyc); end
      checks++;
      if (busy_lo != 0) begin errors++; $display("FAIL t1_busy_drop: got %0d low cycles want 0", busy_lo); end
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || raddr !== 5'd31) begin
         errors++; $display("FAIL t1_to_idle: busy %b raddr %0d want 0 31", busy, raddr);
      end
   endtask

   task automatic test_pattern();
      int bad_w = 0, bad_a = 0;
      fill(12'hA5C);
      start_frame();
      run_frame(1, -1, 0, 12'h0, 1000);
      for (int j = 0; j < 32; j++) if (word_at(j) !== 12'hA5C) bad_w++;
      checks++;
      if (bad_w != 0) begin errors++; $display("FAIL t2_words: %0d bad words, word0 %h want a5c", bad_w, word_at(0)); end
      if (addrs.size() != 32) bad_a = 99;
      else for (int i = 0; i < 32; i++) if (addrs[i] != 31 - i) bad_a++;
      checks++;
      if (bad_a != 0) begin errors++; $display("FAIL t2_addr_seq: %0d bad, length %0d want 32 descending", bad_a, addrs.size()); end
   endtask

   task automatic test_hold();
      tval = 9'd3;
      start_frame();
      run_frame(1, -1, 0, 12'h0, 1000);
      checks++;
      if (fd_cyc - lat_fall != 12) begin
         errors++; $display("FAIL t3_hold_len: got %0d want 12", fd_cyc - lat_fall);
      end
      checks++;
      if (fd_cyc != 846) begin errors++; $display("FAIL t3_frame_done_cycle: got %0d want 846", fd_cyc); end
      tval = 9'd500;
      start_frame();
      run_frame(1, -1, 0, 12'h0, 3000);
      checks++;
      if (fd_cyc - lat_fall != 1916) begin
         errors++; $display("FAIL t3_hold_saturate: got %0d want 1916", fd_cyc - lat_fall);
      end
      tval = 9'd0;
   endtask

   task automatic test_back_to_back();
      start_frame();
      run_frame(-1, -1, 0, 12'h0, 1000);
      checks++;
      if (fd_cyc != 834) begin errors++; $display("FAIL t4_frame1_done: got %0d want 834", fd_cyc); end
      run_frame(100, -1, 0, 12'h0, 1000);
      checks++;
      if (first_addr != 31 || first_busy != 1) begin
         errors++; $display("FAIL t4_reload: raddr %0d busy %0d want 31 1", first_addr, first_busy);
      end
      checks++;
      if (busy_lo != 0) begin errors++; $display("FAIL t4_busy_drop: got %0d low cycles want 0", busy_lo); end
      checks++;
      if (lat_cnt != 1 || fd_cyc != 834) begin
         errors++; $display("FAIL t4_drop_en_frame: latch %0d done %0d want 1 834", lat_cnt, fd_cyc);
      end
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL t4_idle_after_drop: busy %b want 0", busy); end
   endtask

   task automatic test_reset_midframe();
      int found = 0, lat_seen = 0;
      start_frame();
      for (int c = 0; c < 1000 && found == 0; c++) begin
         @(negedge clk);
         if (raddr == 5'd10 && sclk) found = 1;
      end
      checks++;
      if (found == 0) begin errors++; $display("FAIL t5_reach_word10: got 0 want 1"); end
      #2 rstn = 1'b0;
      #1;
      checks++;
      if (raddr !== 5'd31 || {sclk, sdata, latch, busy, fdone} !== 5'b0) begin
         errors++; $display("FAIL t5_async_reset: raddr %0d outs %b want 31 00000", raddr, {sclk, sdata, latch, busy, fdone});
      end
      repeat (3) begin
         @(negedge clk);
         if (latch) lat_seen++;
      end
      checks++;
      if (lat_seen != 0) begin errors++; $display("FAIL t5_no_latch: got %0d want 0", lat_seen); end
      rstn = 1'b1;
      run_frame(1, -1, 0, 12'h0, 1000);
      checks++;
      if (first_addr != 31 || fd_cyc != 834 || lat_cnt != 1) begin
         errors++; $display("FAIL t5_restart: raddr %0d done %0d latch %0d want 31 834 1", first_addr, fd_cyc, lat_cnt);
      end
   endtask

   task automatic test_write_during_scan();
      int bad = 0;
      fill(12'hA5C);
      start_frame();
      run_frame(1, 165, 20, 12'h123, 1000);
      checks++;
      if (word_at(11) !== 12'h123) begin errors++; $display("FAIL t6_new_word20: got %h want 123", word_at(11)); end
      for (int j = 0; j < 32; j++) if (j != 11 && word_at(j) !== 12'hA5C) bad++;
      checks++;
      if (bad != 0) begin errors++; $display("FAIL t6_other_words: %0d bad want 0", bad); end
   endtask

   initial begin
      fill(12'h000);
      test_reset();
      test_single_word();
      test_pattern();
      test_hold();
      test_back_to_back();
      test_reset_midframe();
      test_write_during_scan();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
